// File: rtl/enc_pkg.sv
// enc_pkg: shared types and helpers for the one-hot event encoder.
package enc_pkg;
    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [31:0] onehot(input logic [4:0] idx, input int n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return (32'd1 << idx) & mask;
    endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: combinational priority encoder, lowest or highest set bit wins.
module prio_enc #(
    parameter int N         = 8,
    parameter int IDX_W     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    // The last matching bit in scan order wins, so scan away from the preferred end.
    always_comb begin
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) if (vec[i]) idx = IDX_W'(i);
        end else begin
            for (int i = 0; i < N; i++) if (vec[i]) idx = IDX_W'(i);
        end
    end
    assign any = |vec;
endmodule

// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder: captures event pulses into a sticky pending register and
// issues them one binary index at a time over valid/ready.
module onehot_event_encoder
    import enc_pkg::*;
#(
    parameter int N         = 8,
    parameter int IDX_W     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req_in,
    output logic [IDX_W-1:0] binary_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [N-1:0]     pending_out,
    output logic             overflow_out
);
    if (IDX_W != $clog2(N)) begin : g_bad_idx_w
        $error("IDX_W must equal $clog2(N)");
    end

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] binary_q, binary_d;
    logic             overflow_q, overflow_d;
    logic [N-1:0]     cap, clr, pending_eff, rem;
    logic [IDX_W-1:0] p_idx, r_idx;
    logic             p_any, r_any, accept;

    prio_enc #(.N(N), .IDX_W(IDX_W), .LSB_FIRST(LSB_FIRST)) u_prio_pend (
        .vec(pending_q), .idx(p_idx), .any(p_any)
    );
    prio_enc #(.N(N), .IDX_W(IDX_W), .LSB_FIRST(LSB_FIRST)) u_prio_rem (
        .vec(rem), .idx(r_idx), .any(r_any)
    );

    // Set beats clear: a re-request of the bit being accepted stays pending as a new event.
    always_comb begin
        accept      = (state_q == SEND) && ready_in;
        cap         = req_in & {N{enable}};
        rem         = pending_q & ~N'(onehot(5'(binary_q), N));
        clr         = accept ? N'(onehot(5'(binary_q), N)) : '0;
        pending_eff = pending_q & ~clr;
        pending_d   = pending_eff | cap;
        overflow_d  = |(cap & pending_eff);
        state_d     = state_q;
        binary_d    = binary_q;
        if (state_q == IDLE) begin
            if (p_any) begin
                binary_d = p_idx;
                state_d  = SEND;
            end
        end else if (accept) begin
            binary_d = r_any ? r_idx : binary_q;
            state_d  = r_any ? SEND : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            binary_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            binary_q   <= binary_d;
            overflow_q <= overflow_d;
        end
    end

    assign binary_out   = binary_q;
    assign valid_out    = (state_q == SEND);
    assign pending_out  = pending_q;
    assign overflow_out = overflow_q;
endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb_onehot_event_encoder: directed scenarios with a scoreboard of expected accepted indices.
module tb_onehot_event_encoder;
    logic       clk = 1'b0;
    logic       reset, enable, ready_in, valid_out, overflow_out;
    logic [7:0] req_in, pending_out;
    logic [2:0] binary_out;
    int         checks = 0, errors = 0, ov_cnt = 0;
    int         sb[$];

    onehot_event_encoder #(.N(8), .IDX_W(3), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req_in(req_in),
        .binary_out(binary_out), .valid_out(valid_out), .ready_in(ready_in),
        .pending_out(pending_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted handshake must match the next expected index.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL accept: unexpected idx %0d, scoreboard empty", binary_out);
            end else begin
                int e;
                e = sb.pop_front();
                if (int'(binary_out) != e) begin
                    errors++;
                    $display("FAIL accept: got idx %0d, expected %0d", binary_out, e);
                end
            end
        end
        if (!reset && overflow_out) ov_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req_in = 8'hFF; ready_in = 1'b0;
        step(3);
        chk("reset pending", 32'(pending_out), 0);
        chk("reset valid", 32'(valid_out), 0);
        chk("reset binary", 32'(binary_out), 0);
        chk("reset overflow", 32'(overflow_out), 0);
        reset = 1'b0; req_in = 8'h00;
        step(1);
        // single event
        ready_in = 1'b1; sb.push_back(5); req_in = 8'h20;
        step(1); req_in = 8'h00;
        chk("single pending", 32'(pending_out), 32'h20);
        chk("single valid early", 32'(valid_out), 0);
        step(1);
        chk("single valid", 32'(valid_out), 1);
        chk("single binary", 32'(binary_out), 5);
        step(1);
        chk("single valid drop", 32'(valid_out), 0);
        chk("single pending clear", 32'(pending_out), 0);
        // multi-hot with backpressure
        ready_in = 1'b0; sb.push_back(0); sb.push_back(4); sb.push_back(7); req_in = 8'h91;
        step(1); req_in = 8'h00;
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", 32'(valid_out), 1);
            chk("stall binary", 32'(binary_out), 0);
            step(1);
        end
        ready_in = 1'b1;
        step(3);
        chk("multi valid drop", 32'(valid_out), 0);
        chk("multi pending clear", 32'(pending_out), 0);
        // no pre-emption
        ready_in = 1'b0; sb.push_back(3); sb.push_back(0); req_in = 8'h08;
        step(1); req_in = 8'h00;
        step(1);
        chk("preempt binary", 32'(binary_out), 3);
        req_in = 8'h01;
        step(1); req_in = 8'h00;
        step(2);
        chk("preempt hold", 32'(binary_out), 3);
        chk("preempt pending", 32'(pending_out), 32'h09);
        ready_in = 1'b1;
        step(2);
        chk("preempt valid drop", 32'(valid_out), 0);
        // overflow
        ready_in = 1'b0; ov_cnt = 0; sb.push_back(2); req_in = 8'h04;
        step(1); req_in = 8'h00;
        step(1); req_in = 8'h04;
        step(1); req_in = 8'h00;
        step(2);
        chk("overflow count", 32'(ov_cnt), 1);
        chk("overflow pending", 32'(pending_out), 32'h04);
        ready_in = 1'b1; req_in = 8'h04; sb.push_back(2);
        step(1); req_in = 8'h00;
        step(3);
        chk("rerequest no overflow", 32'(ov_cnt), 1);
        chk("rerequest valid drop", 32'(valid_out), 0);
        chk("rerequest pending", 32'(pending_out), 0);
        // enable and reset
        ready_in = 1'b0; enable = 1'b0; req_in = 8'hFF;
        step(2);
        chk("disable pending", 32'(pending_out), 0);
        chk("disable valid", 32'(valid_out), 0);
        enable = 1'b1; req_in = 8'h02;
        step(1); req_in = 8'h00;
        step(1);
        chk("pre-reset valid", 32'(valid_out), 1);
        chk("pre-reset binary", 32'(binary_out), 1);
        reset = 1'b1;
        step(1);
        chk("mid reset valid", 32'(valid_out), 0);
        chk("mid reset pending", 32'(pending_out), 0);
        reset = 1'b0;
        step(3);
        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
